// File: rtl/tdm_demux.sv
// Four-channel TDM demultiplexer: aligns on frame_sync and assembles serial words into frames.
// Optional parity checking is enabled with `define TDM_DEMUX_PARITY_EN.
module tdm_demux #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_sync,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    input  logic           out_ready,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic           in_par,
    output logic           par_err,
`endif
    output logic [4*W-1:0] out_data,
    output logic           out_valid,
    output logic [1:0]     slot,
    output logic           frame_err,
    output logic           overflow
);

    typedef enum logic {HUNT, RUN} state_t;

    state_t              state;
    logic [2:0][W-1:0]   shadow;
    logic                accept;
    logic                sync_restart;
    logic [1:0]          chan;
    logic                complete;
    logic                load;

`ifdef TDM_DEMUX_PARITY_EN
    logic                word_bad;
    logic                bad;
`endif

    always_comb begin
        accept       = in_valid & ((state == RUN) | frame_sync);
        sync_restart = accept & frame_sync;
        chan         = sync_restart ? 2'd0 : slot;
        complete     = accept & (chan == 2'd3);
`ifdef TDM_DEMUX_PARITY_EN
        word_bad     = ^{in_par, in_data};
        // a frame containing any bad word, including its last one, is dropped
        load         = complete & ~bad & ~word_bad;
`else
        load         = complete;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            slot      <= '0;
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= sync_restart & (state == RUN) & (slot != 2'd0);
            overflow  <= load & out_valid & ~out_ready;

            if (accept) begin
                state <= RUN;
                slot  <= chan + 2'd1;
                if (chan != 2'd3)
                    shadow[chan] <= in_data;
            end

            if (load) begin
                out_data  <= {in_data, shadow[2], shadow[1], shadow[0]};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
            bad     <= 1'b0;
        end else begin
            par_err <= accept & word_bad;
            if (accept) begin
                if (complete)
                    bad <= 1'b0;
                else if (sync_restart)
                    bad <= word_bad;
                else
                    bad <= bad | word_bad;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (W=8): alignment, resync, overflow, handshake, reset.
module tb_tdm_demux;

    logic        clk;
    logic        rst_n;
    logic        frame_sync;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic [1:0]  slot;
    logic        frame_err;
    logic        overflow;
`ifdef TDM_DEMUX_PARITY_EN
    logic        in_par;
    logic        par_err;
    logic        par_flip;
`endif

    int checks;
    int errors;

    tdm_demux #(.W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_sync (frame_sync),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
`ifdef TDM_DEMUX_PARITY_EN
        .in_par     (in_par),
        .par_err    (par_err),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid),
        .slot       (slot),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic s, input logic v, input logic [7:0] d, input logic r);
        frame_sync = s;
        in_valid   = v;
        in_data    = d;
        out_ready  = r;
`ifdef TDM_DEMUX_PARITY_EN
        in_par     = (^d) ^ par_flip;
`endif
        @(posedge clk);
        #1;
        frame_sync = 1'b0;
        in_valid   = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        frame_sync = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        in_par     = 1'b0;
        par_flip   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_slot",      {30'd0, slot},      32'd0);
        check("rst_out_data",  out_data,           32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overflow",  {31'd0, overflow},  32'd0);
        rst_n = 1'b1;

        // Basic aligned frame
        step(1, 1, 8'hA1, 0); check("a1_slot", {30'd0, slot}, 32'd1);
        check("a1_valid", {31'd0, out_valid}, 32'd0);
        step(0, 1, 8'hA2, 0); check("a2_slot", {30'd0, slot}, 32'd2);
        step(0, 1, 8'hA3, 0); check("a3_slot", {30'd0, slot}, 32'd3);
        check("a3_valid", {31'd0, out_valid}, 32'd0);
        step(0, 1, 8'hA4, 0); check("a4_slot", {30'd0, slot}, 32'd0);
        check("a4_valid", {31'd0, out_valid}, 32'd1);
        check("a4_data",  out_data, 32'hA4A3A2A1);
        step(0, 0, 8'h00, 1); check("a_consume_valid", {31'd0, out_valid}, 32'd0);
        check("a_consume_hold", out_data, 32'hA4A3A2A1);

        // Free-running words then mid-frame resync
        step(0, 1, 8'h11, 0); check("f11_slot", {30'd0, slot}, 32'd1);
        check("f11_ferr", {31'd0, frame_err}, 32'd0);
        step(0, 1, 8'h22, 0); check("f22_slot", {30'd0, slot}, 32'd2);
        step(1, 1, 8'h33, 0); check("f33_ferr", {31'd0, frame_err}, 32'd1);
        check("f33_slot", {30'd0, slot}, 32'd1);
        step(0, 1, 8'h44, 0); check("f44_ferr", {31'd0, frame_err}, 32'd0);
        step(0, 1, 8'h55, 0);
        step(0, 1, 8'h66, 0); check("f66_data", out_data, 32'h66554433);
        check("f66_valid", {31'd0, out_valid}, 32'd1);
        check("f66_ovf", {31'd0, overflow}, 32'd0);

        // Second frame with no consumer: overflow
        step(0, 1, 8'hB1, 0);
        step(0, 1, 8'hB2, 0);
        step(0, 1, 8'hB3, 0); check("b3_ovf", {31'd0, overflow}, 32'd0);
        step(0, 1, 8'hB4, 0); check("b4_ovf", {31'd0, overflow}, 32'd1);
        check("b4_data",  out_data, 32'hB4B3B2B1);
        check("b4_valid", {31'd0, out_valid}, 32'd1);
        step(0, 0, 8'h00, 0); check("b_ovf_pulse", {31'd0, overflow}, 32'd0);
        check("b_hold_valid", {31'd0, out_valid}, 32'd1);
        step(0, 0, 8'h00, 1); check("b_consume_valid", {31'd0, out_valid}, 32'd0);
        check("b_consume_hold", out_data, 32'hB4B3B2B1);

        // Completion coincident with out_ready
        step(0, 1, 8'hC1, 0);
        step(0, 1, 8'hC2, 0);
        step(0, 1, 8'hC3, 0);
        step(0, 1, 8'hC4, 0); check("c4_valid", {31'd0, out_valid}, 32'd1);
        check("c4_ovf", {31'd0, overflow}, 32'd0);
        step(0, 1, 8'hD1, 0);
        step(0, 1, 8'hD2, 0);
        step(0, 1, 8'hD3, 0);
        step(0, 1, 8'hD4, 1); check("d4_ovf", {31'd0, overflow}, 32'd0);
        check("d4_valid", {31'd0, out_valid}, 32'd1);
        check("d4_data",  out_data, 32'hD4D3D2D1);
        step(0, 0, 8'h00, 1); check("d_consume_valid", {31'd0, out_valid}, 32'd0);

        // frame_sync without in_valid mid-frame is ignored
        step(0, 1, 8'hE1, 0);
        step(0, 1, 8'hE2, 0);
        step(1, 0, 8'h99, 0); check("e_sync_novalid_slot", {30'd0, slot}, 32'd2);
        check("e_sync_novalid_ferr", {31'd0, frame_err}, 32'd0);
        step(0, 1, 8'hE3, 0);
        step(0, 1, 8'hE4, 0); check("e4_data", out_data, 32'hE4E3E2E1);
        check("e4_valid", {31'd0, out_valid}, 32'd1);
        step(0, 0, 8'h00, 1);

        // Reset mid-frame, then hunting
        step(0, 1, 8'hF1, 0);
        step(0, 1, 8'hF2, 0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_slot",  {30'd0, slot},      32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data",  out_data,           32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h77, 0);
            check("hunt_slot",  {30'd0, slot},      32'd0);
            check("hunt_valid", {31'd0, out_valid}, 32'd0);
        end
        step(1, 0, 8'h00, 0); check("hunt_sync_novalid_slot", {30'd0, slot}, 32'd0);
        step(1, 1, 8'h01, 0); check("g1_slot", {30'd0, slot}, 32'd1);
        step(0, 1, 8'h02, 0);
        step(0, 1, 8'h03, 0);
        step(0, 1, 8'h04, 0); check("g4_data", out_data, 32'h04030201);
        check("g4_valid", {31'd0, out_valid}, 32'd1);
        step(0, 0, 8'h00, 1); check("g_consume_valid", {31'd0, out_valid}, 32'd0);

`ifdef TDM_DEMUX_PARITY_EN
        // Bad parity on one word drops that frame only
        step(0, 1, 8'h51, 0); check("h1_perr", {31'd0, par_err}, 32'd0);
        par_flip = 1'b1;
        step(0, 1, 8'h52, 0); check("h2_perr", {31'd0, par_err}, 32'd1);
        par_flip = 1'b0;
        step(0, 1, 8'h53, 0); check("h3_perr", {31'd0, par_err}, 32'd0);
        step(0, 1, 8'h54, 0); check("h4_valid", {31'd0, out_valid}, 32'd0);
        check("h4_data", out_data, 32'h04030201);
        step(0, 1, 8'h61, 0);
        step(0, 1, 8'h62, 0);
        step(0, 1, 8'h63, 0);
        step(0, 1, 8'h64, 0); check("j4_valid", {31'd0, out_valid}, 32'd1);
        check("j4_data", out_data, 32'h64636261);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter W, default 8: width of one channel word.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 frame_sync  input  1  marks the in_valid word as channel 0 of a new frame.
REQ-005 in_valid  input  1  in_data holds a valid word this cycle.
REQ-006 in_data  input  W  serial channel word.
REQ-007 out_ready  input  1  consumer accepts out_data this cycle.
REQ-008 out_data  output  4*W  assembled frame; channel k at bits [k*W +: W].
REQ-009 out_valid  output  1  out_data holds an unconsumed frame.
REQ-010 slot  output  2  channel index the next accepted word is written to.
REQ-011 frame_err  output  1  one-cycle pulse: sync arrived mid-frame.
REQ-012 overflow  output  1  one-cycle pulse: unconsumed frame overwritten.

Function
REQ-013 Two-state FSM: HUNT (no frame alignment) and RUN (aligned).
REQ-014 HUNT: in_valid without frame_sync is ignored; slot stays 0.
REQ-015 HUNT, in_valid and frame_sync: word goes to shadow channel 0, slot becomes 1, next state RUN.
REQ-016 RUN, in_valid: word goes to shadow channel slot, and slot increments modulo 4.
REQ-017 RUN, in_valid with slot==3: the complete frame (shadow 0..2 plus the current word) is loaded into out_data on the same edge, and out_valid is set; latency is one clock from the last word to out_valid.
REQ-018 RUN, in_valid with slot==0 and no frame_sync: accepted as channel 0 (free-running alignment).
REQ-019 RUN, in_valid and frame_sync with slot!=0: partial frame discarded, frame_err pulses, word stored as channel 0, slot becomes 1.
REQ-020 frame_sync without in_valid: ignored in both states.
REQ-021 out_valid clears on out_ready while out_valid is high, unless a new frame loads the same cycle.
REQ-022 Frame completes while out_valid is high and out_ready is low: out_data is overwritten, out_valid stays 1, overflow pulses.
REQ-023 Frame completes in the same cycle as out_ready: the new frame loads, out_valid stays 1, and there is no overflow.
REQ-024 out_data holds its value while no frame loads; it does not change when out_valid clears.

Reset
REQ-025 On rst_n low: state is HUNT, slot is 0, the shadow registers and out_data are 0, and out_valid, frame_err and overflow are 0.
REQ-026 Reset asserted mid-frame discards the partial frame; after release, the block re-enters alignment only on frame_sync.

Configuration
REQ-027 Macro TDM_DEMUX_PARITY_EN.
REQ-028 Macro defined: the block adds input in_par (1 bit) and output par_err (1 bit). Even parity over {in_par, in_data} is checked on every accepted word. On a mismatch, par_err pulses for one cycle and the current frame is marked bad. A bad frame does not load out_data or set out_valid. The bad mark clears when a frame completes or on a sync restart.
REQ-029 Macro undefined: in_par and par_err are absent, and there is no parity checking.

Verification
REQ-030 Reset, then sync+A1,A2,A3,A4 on consecutive cycles: the cycle after A4, out_valid=1 and out_data={A4,A3,A2,A1}; slot sequence is 1,2,3,0.
REQ-031 In HUNT, 3 valid words without sync: slot stays 0 and out_valid stays 0; the next sync word yields slot=1.
REQ-032 Words 11,22 then sync+33,44,55,66: frame_err pulses once at 33, and out_data={66,55,44,33}.
REQ-033 Two complete frames with out_ready=0: overflow pulses at the second completion, and out_data holds the second frame. Then out_ready=1 for one cycle: out_valid becomes 0.
REQ-034 Frame completion coincident with out_ready=1 while out_valid=1: no overflow, out_valid stays 1, and the new data loads.
REQ-035 With TDM_DEMUX_PARITY_EN, one word with bad parity: par_err pulses and that frame is not delivered; the following good frame is delivered.
